instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/cpu_fetch_pkg.sv | 20 ++
 rtl/ifu_next_pc.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 115 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// next-PC select codes and the opcode that halts fetching.
package cpu_fetch_pkg;

    typedef enum logic [2:0] {
        S_REQ,
        S_ISSUE,
        S_RESOLVE,
        S_HALT,
        S_FAULT
    } fetch_state_e;

    localparam logic [1:0] JMP_SEQ = 2'd0;
    localparam logic [1:0] JMP_REL = 2'd1;
    localparam logic [1:0] JMP_REG = 2'd2;
    localparam logic [1:0] JMP_ABS = 2'd3;

    localparam logic [5:0] HALT_OPCODE = 6'b000000;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC computation and word-alignment check for the fetch unit.
module ifu_next_pc
    import cpu_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  jump_sel,
    input  logic [31:0] reg1_data,
    input  logic [31:0] im_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    // NOTE: next_pc gets a default first, so no path through the case can infer a latch.
    always_comb begin
        next_pc = pc + 32'd4;
        case (jump_sel)
            JMP_SEQ: next_pc = pc + 32'd4;
            JMP_REL: next_pc = pc + {im_data[29:0], 2'b00};
            JMP_REG: next_pc = reg1_data;
            JMP_ABS: next_pc = {pc[31:18], im_data[15:0], 2'b00};
            default: next_pc = pc + 32'd4;
        endcase
    end

    // Only register jumps can produce a non-word-aligned target.
    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch FSM: requests a word at pc, issues it to the decoder for
// one cycle, then waits for the decoder's permission to load the next PC.
module instruction_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        PC_enable,
    input  logic [1:0]  jump_mux_signal,
    input  logic [31:0] reg1_data,
    input  logic [31:0] im_data,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fault
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    fetch_state_e state, state_next;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [CNT_W-1:0] wait_cnt;

    logic [31:0] next_pc;
    logic        misaligned;
    logic        timeout_hit;
    logic        pc_load;
    logic        capture;
    logic        cnt_clr;
    logic        cnt_inc;

    ifu_next_pc u_next_pc (
        .pc         (pc_q),
        .jump_sel   (jump_mux_signal),
        .reg1_data  (reg1_data),
        .im_data    (im_data),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // The last waiting cycle is the one where the counter equals ACK_TIMEOUT-1.
    assign timeout_hit = (ACK_TIMEOUT != 0) && (wait_cnt == CNT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        capture    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            S_REQ: begin
                if (imem_ack) begin
                    capture    = 1'b1;
                    state_next = S_ISSUE;
                end else if (timeout_hit) begin
                    state_next = S_FAULT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_ISSUE: begin
                state_next = (instr_q[31:26] == HALT_OPCODE) ? S_HALT : S_RESOLVE;
            end
            S_RESOLVE: begin
                if (PC_enable) begin
                    if (misaligned) begin
                        state_next = S_FAULT;
                    end else begin
                        pc_load    = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = S_REQ;
                    end
                end
            end
            S_HALT:  state_next = S_HALT;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FAULT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (pc_load) pc_q <= next_pc;
            if (capture) instr_q <= imem_rdata;
            if (cnt_clr) wait_cnt <= '0;
            else if (cnt_inc && ACK_TIMEOUT != 0) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Request is gated by reset so an in-flight fetch is dropped the moment reset asserts.
    assign imem_req    = rst && (state == S_REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = (state == S_ISSUE);
    assign halted      = (state == S_HALT);
    assign fault       = (state == S_FAULT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table,
// randomized fetch/jump sequences against an arithmetic PC model, and reset/halt/timeout corners.
module tb_instruction_fetch_unit;
    import cpu_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        PC_enable = 1'b0;
    logic [1:0]  jump_mux_signal = 2'd0;
    logic [31:0] reg1_data = '0;
    logic [31:0] im_data = '0;
    logic [31:0] pc;
    logic        halted;
    logic        fault;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] m_pc = 32'h0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instruction     (instruction),
        .instr_valid     (instr_valid),
        .PC_enable       (PC_enable),
        .jump_mux_signal (jump_mux_signal),
        .reg1_data       (reg1_data),
        .im_data         (im_data),
        .pc              (pc),
        .halted          (halted),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference next-PC from the jump rules, using plain integer arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] sel,
                                               input logic [31:0] r1, input logic [31:0] imm);
        case (sel)
            2'd0:    return cur + 32'd4;
            2'd1:    return cur + imm * 32'd4;
            2'd2:    return r1;
            default: return (cur & 32'hFFFC_0000) | ((imm & 32'h0000_FFFF) * 32'd4);
        endcase
    endfunction

    // Entered at a negedge with the DUT in its first REQ cycle for address m_pc.
    task automatic run_fetch(input logic [31:0] word, input int delay, input int stall,
                             input logic [1:0] sel, input logic [31:0] r1, input logic [31:0] imm,
                             input logic [31:0] exp_pc, input logic exp_fault);
        logic [31:0] start_pc;
        start_pc = m_pc;
        for (int i = 0; i <= delay; i++) begin
            check("req_high", imem_req, 1);
            check("req_addr", imem_addr, start_pc);
            imem_ack   = (i == delay);
            imem_rdata = (i == delay) ? word : $urandom;
            @(negedge clk);
        end
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("issue_valid", instr_valid, 1);
        check("issue_word", instruction, word);
        check("issue_no_req", imem_req, 0);
        if (word[31:26] == 6'd0) begin
            @(negedge clk);
            check("halt_flag", halted, 1);
            check("halt_no_req", imem_req, 0);
            check("halt_no_valid", instr_valid, 0);
            return;
        end
        jump_mux_signal = sel;
        reg1_data       = r1;
        im_data         = imm;
        PC_enable       = 1'b0;
        @(negedge clk);
        for (int i = 0; i < stall; i++) begin
            check("stall_pc", pc, start_pc);
            check("stall_no_req", imem_req, 0);
            check("stall_no_valid", instr_valid, 0);
            @(negedge clk);
        end
        PC_enable = 1'b1;
        @(negedge clk);
        PC_enable = 1'b0;
        check("next_pc", pc, exp_pc);
        check("fault_flag", fault, exp_fault);
        check("req_after_resolve", imem_req, !exp_fault);
        check("word_held", instruction, word);
        m_pc = exp_pc;
    endtask

    task automatic release_reset(input logic stale_ack);
        @(negedge clk);
        rst      = 1'b1;
        imem_ack = stale_ack;
        m_pc     = 32'h0;
        #1;
    endtask

    typedef struct {
        logic [31:0] word;
        int          delay;
        int          stall;
        logic [1:0]  sel;
        logic [31:0] r1;
        logic [31:0] imm;
        logic [31:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'h0400_0000, 1, 0, JMP_SEQ, 32'h0,     32'h0,         32'h0000_0004, 1'b0};
        vecs[1] = '{32'h0800_0001, 0, 0, JMP_REG, 32'h100,   32'h0,         32'h0000_0100, 1'b0};
        vecs[2] = '{32'h0C00_0002, 2, 1, JMP_REL, 32'h0,     32'hFFFF_FFFC, 32'h0000_00F0, 1'b0};
        vecs[3] = '{32'h1000_0003, 3, 0, JMP_ABS, 32'h0,     32'h0000_0040, 32'h0000_0100, 1'b0};
        vecs[4] = '{32'hFC00_FFFF, 0, 5, JMP_SEQ, 32'h0,     32'h0,         32'h0000_0104, 1'b0};

        // Reset state, with a spurious ack that must be ignored.
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_valid", instr_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_halted", halted, 0);
        check("rst_fault", fault, 0);
        release_reset(1'b0);

        for (int v = 0; v < 5; v++)
            run_fetch(vecs[v].word, vecs[v].delay, vecs[v].stall, vecs[v].sel,
                      vecs[v].r1, vecs[v].imm, vecs[v].exp_pc, vecs[v].exp_fault);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] word, r1, imm;
            logic [1:0]  sel;
            word = $urandom;
            if (word[31:26] == 6'd0) word[26] = 1'b1;
            sel = 2'($urandom_range(0, 3));
            r1  = $urandom & 32'hFFFF_FFFC;
            imm = $urandom;
            run_fetch(word, $urandom_range(0, 3), $urandom_range(0, 2), sel, r1, imm,
                      model_next(m_pc, sel, r1, imm), 1'b0);
        end

        // Misaligned register target: fault, pc held, no further requests.
        run_fetch(32'h2000_0000, 0, 0, JMP_REG, 32'h203, 32'h0, m_pc, 1'b1);
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        check("fault_sticky", fault, 1);
        check("fault_no_req", imem_req, 0);
        check("fault_pc_held", pc, m_pc);
        check("fault_no_valid", instr_valid, 0);

        // Reset mid-fetch, then a stale ack at release fetches RESET_PC (a halt word).
        rst = 1'b0;
        release_reset(1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_req", imem_req, 0);
        check("midrst_pc", pc, 32'h0);
        imem_rdata = 32'h0000_0000;
        release_reset(1'b1);
        run_fetch(32'h0000_0000, 0, 0, JMP_SEQ, 32'h0, 32'h0, 32'h0, 1'b0);
        imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        check("halt_sticky", halted, 1);
        check("halt_no_fault", fault, 0);
        check("halt_pc", pc, 32'h0);

        // Timeout: four REQ cycles with no ack lead to fault.
        rst = 1'b0;
        release_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            check("to_req", imem_req, 1);
            check("to_no_fault", fault, 0);
            @(negedge clk);
        end
        check("to_fault", fault, 1);
        check("to_no_req", imem_req, 0);
        check("to_pc", pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
